// File: rtl/control_unit.sv
// Main decoder for the pipelined MIPS core (ID stage).
// Decodes the 6-bit opcode into datapath control signals plus an IF/ID flush
// request. All outputs are registered (one-cycle latency) and feed the ID/EX
// pipeline register.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous, active-high; clears every output
//   stall    - hazard-unit bubble request; loads every output with 0
//   opcode   - instruction bits [31:26]
//   Regdst, Jump, Branch, Memread, MemtoReg, Memwrite, ALUSrc, Regwrite,
//   ALUOp[1:0], flush - registered control outputs
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [5:0] opcode,
  output logic       Regdst,
  output logic       Jump,
  output logic       Branch,
  output logic       Memread,
  output logic       MemtoReg,
  output logic       Memwrite,
  output logic       ALUSrc,
  output logic       Regwrite,
  output logic [1:0] ALUOp,
  output logic       flush
);

  typedef struct packed {
    logic       regdst;
    logic       jump;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
    logic       flush;
  } ctrl_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAlt0  = 6'b100000;
  localparam logic [5:0] OpAlt1  = 6'b100010;
  localparam logic [5:0] OpAlt2  = 6'b100100;
  localparam logic [5:0] OpAlt3  = 6'b100101;
  localparam logic [5:0] OpAlt4  = 6'b101010;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  ctrl_t ctrl_d, ctrl_q;

  // Combinational decode; unknown or X/Z opcodes fall to the all-zero NOP.
  always_comb begin
    ctrl_d = '0;
    case (opcode)
      OpRtype, OpAlt0, OpAlt1, OpAlt2, OpAlt3, OpAlt4: begin
        ctrl_d.regdst   = 1'b1;
        ctrl_d.regwrite = 1'b1;
        ctrl_d.aluop    = AluFunct;
      end
      OpLw: begin
        ctrl_d.memread  = 1'b1;
        ctrl_d.memtoreg = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.regwrite = 1'b1;
        ctrl_d.aluop    = AluAdd;
      end
      OpSw: begin
        ctrl_d.memwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.aluop    = AluAdd;
      end
      OpBeq: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.aluop  = AluSub;
        ctrl_d.flush  = 1'b1;
      end
      OpJ: begin
        ctrl_d.jump  = 1'b1;
        ctrl_d.flush = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // Reset has priority over stall; both insert an all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
    end else if (stall) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign Regdst   = ctrl_q.regdst;
  assign Jump     = ctrl_q.jump;
  assign Branch   = ctrl_q.branch;
  assign Memread  = ctrl_q.memread;
  assign MemtoReg = ctrl_q.memtoreg;
  assign Memwrite = ctrl_q.memwrite;
  assign ALUSrc   = ctrl_q.alusrc;
  assign Regwrite = ctrl_q.regwrite;
  assign ALUOp    = ctrl_q.aluop;
  assign flush    = ctrl_q.flush;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes the model's expected
// output word per edge; a monitor pops and compares one cycle later.
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic       stall;
  logic [5:0] opcode;
  logic       Regdst, Jump, Branch, Memread, MemtoReg, Memwrite, ALUSrc, Regwrite, flush;
  logic [1:0] ALUOp;

  int vectors;
  int miscompares;
  logic [10:0] exp_q[$];
  bit inv_armed;

  control_unit dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .opcode   (opcode),
    .Regdst   (Regdst),
    .Jump     (Jump),
    .Branch   (Branch),
    .Memread  (Memread),
    .MemtoReg (MemtoReg),
    .Memwrite (Memwrite),
    .ALUSrc   (ALUSrc),
    .Regwrite (Regwrite),
    .ALUOp    (ALUOp),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: derived from instruction class semantics.
  // Word layout: {Rd, J, Br, MR, M2R, MW, AS, RW, ALUOp[1:0], fl}.
  function automatic logic [10:0] model(input logic r, input logic s, input logic [5:0] op);
    logic [5:0] rtype_ops[6];
    bit is_r, is_lw, is_sw, is_beq, is_j;
    logic [1:0] aluop;
    rtype_ops = '{6'b000000, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    is_r = 1'b0;
    foreach (rtype_ops[i]) if (op == rtype_ops[i]) is_r = 1'b1;
    is_lw  = (op == 6'd35);
    is_sw  = (op == 6'd43);
    is_beq = (op == 6'd4);
    is_j   = (op == 6'd2);
    if (r || s) return 11'd0;
    aluop = is_r ? 2'd2 : (is_beq ? 2'd1 : 2'd0);
    return {is_r, is_j, is_beq, is_lw, is_lw, is_sw, (is_lw || is_sw), (is_r || is_lw),
            aluop, (is_beq || is_j)};
  endfunction

  task automatic apply(input logic r, input logic s, input logic [5:0] op);
    @(negedge clk);
    reset  = r;
    stall  = s;
    opcode = op;
    exp_q.push_back(model(r, s, op));
  endtask

  // Monitor: outputs are valid every cycle once stimulus has started.
  initial begin
    logic [10:0] got, exp;
    forever begin
      @(posedge clk);
      #1;
      got = {Regdst, Jump, Branch, Memread, MemtoReg, Memwrite, ALUSrc, Regwrite, ALUOp, flush};
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL ctrl_word t=%0t got=%b expected=%b", $time, got, exp);
        end
      end
      if (inv_armed) begin
        vectors++;
        if ((Memread && Memwrite) || (Jump && Branch)) begin
          miscompares++;
          $display("FAIL exclusivity t=%0t MR/MW=%b%b J/Br=%b%b expected no pair both 1",
                   $time, Memread, Memwrite, Jump, Branch);
        end
      end
    end
  end

  initial begin
    logic [5:0] valid_ops[10];
    logic [5:0] op;
    valid_ops = '{6'b000000, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                  6'b100011, 6'b101011, 6'b000100, 6'b000010};
    vectors     = 0;
    miscompares = 0;
    inv_armed   = 1'b0;
    reset  = 1'b1;
    stall  = 1'b0;
    opcode = 6'b100011;

    // Reset held two edges with lw present, then lw decodes.
    apply(1'b1, 1'b0, 6'b100011);
    apply(1'b1, 1'b0, 6'b100011);
    inv_armed = 1'b1;
    apply(1'b0, 1'b0, 6'b100011);
    // R-type sweep.
    for (int i = 0; i < 6; i++) apply(1'b0, 1'b0, valid_ops[i]);
    apply(1'b0, 1'b0, 6'b100011);
    apply(1'b0, 1'b0, 6'b101011);
    apply(1'b0, 1'b0, 6'b000100);
    apply(1'b0, 1'b0, 6'b000010);
    apply(1'b0, 1'b0, 6'b111111);
    apply(1'b0, 1'b0, 6'b000000);
    // Stall bubble, then recovery.
    apply(1'b0, 1'b1, 6'b100011);
    apply(1'b0, 1'b0, 6'b100011);
    // Mid-stream reset, and reset overriding stall.
    apply(1'b1, 1'b0, 6'b000010);
    apply(1'b1, 1'b1, 6'b000100);
    apply(1'b0, 1'b0, 6'b000100);

    // Randomised traffic biased toward defined opcodes.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(9) < 7) op = valid_ops[$urandom_range(9)];
      else op = 6'($urandom);
      apply(($urandom_range(19) == 0), ($urandom_range(7) == 0), op);
    end

    // Drain: the last expected word is consumed on the next edge.
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain leftover=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
